// File: rtl/pc_fetch_unit.sv
// Program-counter register and instruction-fetch sequencer (IDLE/FETCH/HOLD/HALT/ERR).
// Optional FETCH_ALIGN_CHECK_EN: a misaligned curPC on FETCH entry suppresses imem_req and raises fetch_err.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] nextPC,
    input  logic        PCWre,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        inst_ready,
    output logic [31:0] curPC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        fetch_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_HALT,
        S_ERR
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_cur_pc;
    logic [31:0] r_inst;
    logic [7:0]  r_tmo_cnt;
    logic        r_fetch_err;
    logic        w_misaligned;
    logic        w_req;
    logic        w_capture;
    logic        w_load_pc;
    logic        w_set_err;

`ifdef FETCH_ALIGN_CHECK_EN
    assign w_misaligned = (r_cur_pc[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next    = r_state;
        w_req     = 1'b0;
        w_capture = 1'b0;
        w_load_pc = 1'b0;
        w_set_err = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                if (w_misaligned) begin
                    w_set_err = 1'b1;
                    w_next    = S_ERR;
                end else begin
                    w_req = 1'b1;
                    // Ack takes priority over a timeout firing in the same cycle.
                    if (imem_ack) begin
                        w_capture = 1'b1;
                        w_next    = S_HOLD;
                    end else if (r_tmo_cnt == TMO_LAST) begin
                        w_set_err = 1'b1;
                        w_next    = S_ERR;
                    end
                end
            end
            S_HOLD: begin
                if (inst_ready) begin
                    if (PCWre) begin
                        w_load_pc = 1'b1;
                        w_next    = S_FETCH;
                    end else begin
                        w_next = S_HALT;
                    end
                end
            end
            S_HALT: begin
                if (PCWre) begin
                    w_load_pc = 1'b1;
                    w_next    = S_FETCH;
                end
            end
            S_ERR:   w_next = S_ERR;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_cur_pc    <= RESET_PC;
            r_inst      <= 32'h0;
            r_tmo_cnt   <= 8'h0;
            r_fetch_err <= 1'b0;
        end else begin
            if (w_load_pc) r_cur_pc <= nextPC;
            if (w_capture) r_inst <= imem_rdata;
            if (w_set_err) r_fetch_err <= 1'b1;
            if (r_state == S_FETCH && w_next == S_FETCH) r_tmo_cnt <= r_tmo_cnt + 8'h1;
            else                                         r_tmo_cnt <= 8'h0;
        end
    end

    assign curPC      = r_cur_pc;
    assign imem_addr  = {r_cur_pc[31:2], 2'b00};
    assign imem_req   = w_req;
    assign inst       = r_inst;
    assign inst_valid = (r_state == S_HOLD);
    assign fetch_err  = r_fetch_err;
    assign busy       = (r_state == S_FETCH) || (r_state == S_HOLD);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit (TIMEOUT_CYCLES=4); expectations follow FETCH_ALIGN_CHECK_EN if defined.
module tb_pc_fetch_unit;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] nextPC;
    logic        PCWre;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_ready;
    logic [31:0] curPC;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] inst;
    logic        inst_valid;
    logic        fetch_err;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    pc_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .Reset(Reset), .nextPC(nextPC), .PCWre(PCWre),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_ready(inst_ready),
        .curPC(curPC), .imem_req(imem_req), .imem_addr(imem_addr), .inst(inst),
        .inst_valid(inst_valid), .fetch_err(fetch_err), .busy(busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " curPC"},      curPC, 32'h0);
        check({tag, " imem_req"},   {31'b0, imem_req}, 32'h0);
        check({tag, " inst"},       inst, 32'h0);
        check({tag, " inst_valid"}, {31'b0, inst_valid}, 32'h0);
        check({tag, " fetch_err"},  {31'b0, fetch_err}, 32'h0);
        check({tag, " busy"},       {31'b0, busy}, 32'h0);
    endtask

    initial begin
        Reset      = 1'b0;
        nextPC     = 32'h4;
        PCWre      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'h2001_0005;
        inst_ready = 1'b1;
        #12;
        check_reset_vals("por");
        Reset = 1'b1;

        // Ack in the first FETCH cycle, immediate consumption.
        step();
        check("t1 req", {31'b0, imem_req}, 32'h1);
        check("t1 addr", imem_addr, 32'h0);
        check("t1 valid0", {31'b0, inst_valid}, 32'h0);
        step();
        check("t1 valid", {31'b0, inst_valid}, 32'h1);
        check("t1 inst", inst, 32'h2001_0005);
        check("t1 req_hold", {31'b0, imem_req}, 32'h0);
        step();
        check("t1 curPC", curPC, 32'h4);
        check("t1 req2", {31'b0, imem_req}, 32'h1);
        check("t1 valid_drop", {31'b0, inst_valid}, 32'h0);

        // Ack in the 4th FETCH cycle (also the timeout cycle), decode stalls 5 cycles.
        imem_ack   = 1'b0;
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t2 req", {31'b0, imem_req}, 32'h1);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        check("t2 req_off", {31'b0, imem_req}, 32'h0);
        check("t2 no_err", {31'b0, fetch_err}, 32'h0);
        imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) step();
            check("t2 valid", {31'b0, inst_valid}, 32'h1);
            check("t2 inst", inst, 32'hDEAD_BEEF);
            check("t2 curPC", curPC, 32'h4);
        end
        inst_ready = 1'b1;
        nextPC     = 32'h8;
        step();
        check("t2 curPC_adv", curPC, 32'h8);
        check("t2 req_adv", {31'b0, imem_req}, 32'h1);

        // Halt on consumption with PCWre=0, resume 4 cycles later.
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_00AA;
        step();
        check("t3 valid", {31'b0, inst_valid}, 32'h1);
        PCWre    = 1'b0;
        nextPC   = 32'h10;
        imem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t3 halt_valid", {31'b0, inst_valid}, 32'h0);
            check("t3 halt_req", {31'b0, imem_req}, 32'h0);
            check("t3 halt_pc", curPC, 32'h8);
            check("t3 halt_busy", {31'b0, busy}, 32'h0);
        end
        PCWre = 1'b1;
        step();
        check("t3 resume_pc", curPC, 32'h10);
        check("t3 resume_req", {31'b0, imem_req}, 32'h1);
        check("t3 resume_addr", imem_addr, 32'h10);

        // No ack: error after the 4th FETCH cycle, sticky.
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4 req", {31'b0, imem_req}, 32'h1);
            check("t4 err0", {31'b0, fetch_err}, 32'h0);
        end
        step();
        check("t4 err", {31'b0, fetch_err}, 32'h1);
        check("t4 req_off", {31'b0, imem_req}, 32'h0);
        imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4 sticky", {31'b0, fetch_err}, 32'h1);
            check("t4 err_req", {31'b0, imem_req}, 32'h0);
            check("t4 err_valid", {31'b0, inst_valid}, 32'h0);
        end

        // Reset clears ERR; then reset mid-FETCH and mid-HOLD.
        #3 Reset = 1'b0;
        #1 check_reset_vals("rst_err");
        imem_ack = 1'b0;
        Reset    = 1'b1;
        step();
        check("t5 req", {31'b0, imem_req}, 32'h1);
        check("t5 addr", imem_addr, 32'h0);
        #3 Reset = 1'b0;
        #1 check_reset_vals("rst_fetch");
        #1 Reset = 1'b1;
        step();
        check("t5 refetch", {31'b0, imem_req}, 32'h1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1111_2222;
        nextPC     = 32'h20;
        step();
        step();
        check("t5 pc20", curPC, 32'h20);
        inst_ready = 1'b0;
        step();
        check("t5 hold_valid", {31'b0, inst_valid}, 32'h1);
        check("t5 hold_inst", inst, 32'h1111_2222);
        #3 Reset = 1'b0;
        #1 check_reset_vals("rst_hold");
        #1 Reset = 1'b1;
        imem_ack = 1'b0;
        step();
        check("t5 post_req", {31'b0, imem_req}, 32'h1);
        check("t5 post_addr", imem_addr, 32'h0);

        // Misaligned next PC.
        imem_ack   = 1'b1;
        imem_rdata = 32'h3333_4444;
        inst_ready = 1'b1;
        nextPC     = 32'h6;
        step();
        check("t6 inst", inst, 32'h3333_4444);
        step();
        check("t6 curPC", curPC, 32'h6);
        check("t6 err0", {31'b0, fetch_err}, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("t6 req_supp", {31'b0, imem_req}, 32'h0);
        step();
        check("t6 err", {31'b0, fetch_err}, 32'h1);
        check("t6 req_err", {31'b0, imem_req}, 32'h0);
`else
        check("t6 req", {31'b0, imem_req}, 32'h1);
        check("t6 addr", imem_addr, 32'h4);
        step();
        check("t6 valid", {31'b0, inst_valid}, 32'h1);
        check("t6 no_err", {31'b0, fetch_err}, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
